branch_prediction_unit: RTL
===========================

BRANCH_PREDICTION_UNIT -- requirements
Module: bpu

Interface
REQ-001 Parameter BTB_LOGSIZE, default 4, log2 of BTB entry count (16 entries).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 fetch_pc  in  32  PC currently in Fetch; lookup key.
REQ-005 stall  in  1  freezes the Fetch/Decode boundary; no prediction advance, no table update.
REQ-006 opcode  in  `opcode_size  Decode-stage instruction opcode.
REQ-007 funct3  in  3  Decode-stage branch condition.
REQ-008 dec_pc, dec_imm  in  32 each  Decode-stage PC and sign-extended immediate.
REQ-009 rs1_data, rs2_data  in  32 each  register-file read data.
REQ-010 fw_data  in  32  result forwarded from the Memory stage.
REQ-011 br_fwsel1, br_fwsel2  in  1 each  select fw_data instead of rs1_data / rs2_data.
REQ-012 pred_taken  out  1  Fetch redirect to pred_target next cycle.
REQ-013 pred_target  out  32  predicted next PC.
REQ-014 mispredict  out  1  Decode resolution disagrees with the prediction carried into Decode.
REQ-015 correct_pc  out  32  PC Fetch loads when mispredict is 1.

Function
REQ-016 Operands: op1 = br_fwsel1 ? fw_data : rs1_data; op2 = br_fwsel2 ? fw_data : rs2_data.
REQ-017 BTB entry: valid, tag = fetch_pc[31:BTB_LOGSIZE+2], 32-bit target, 2-bit counter; index = fetch_pc[BTB_LOGSIZE+1:2].
REQ-018 Lookup is combinational: pred_taken = valid AND tag match AND counter[1]; pred_target = entry target when pred_taken, else fetch_pc+4.
REQ-019 Counter states 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; taken increments, not-taken decrements, saturating at 00 and 11.
REQ-020 On each clock edge with stall=0, pred_taken and pred_target are registered into Decode as dp_taken, dp_target; with stall=1 they hold.
REQ-021 Btype resolution: taken per funct3 as 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; target = dec_pc + dec_imm.
REQ-022 Btype with funct3 010 or 011 resolves as not-taken and updates nothing.
REQ-023 jalr resolution: always taken; target = (op1 + dec_imm) with bit 0 cleared.
REQ-024 Other opcodes: mispredict = 0, no update.
REQ-025 mispredict = 1 when the resolved direction differs from dp_taken, or when both are taken and the resolved target differs from dp_target; combinational in Decode.
REQ-026 correct_pc = resolved target when resolved taken, else dec_pc+4.
REQ-027 mispredict is forced to 0 while stall=1.
REQ-028 Update happens at the clock edge after resolution, only with stall=0, and only for btype or jalr.
REQ-029 Hit: counter moves per REQ-019; when resolved taken, the target is rewritten.
REQ-030 Miss: a taken outcome allocates the entry with valid=1, new tag, resolved target and counter 10; a not-taken outcome allocates nothing.
REQ-031 Same-cycle update and lookup to the same index: the lookup returns pre-update contents (no bypass).
REQ-032 Arithmetic is modulo 2^32; address wrap at 0xFFFFFFFC+4 = 0 is legal.

Reset
REQ-033 On rst, all valid bits clear, all counters go to 01, targets and tags go to 0, and dp_taken/dp_target go to 0.
REQ-034 During and after reset, pred_taken=0, pred_target=fetch_pc+4 and mispredict=0 until a non-stalled edge loads Decode.
REQ-035 rst asserted mid-operation discards any pending update.

Structure
REQ-036 `btype_op, `jalr_op, `opcode_size and the funct3 codes come from the shared constants file; the 2-bit counter state typedef goes into the shared package.
REQ-037 One sub-module, bpu_cond, holds the purely combinational funct3 comparator.
REQ-038 BTB storage is a flop array with no memory macro.

Verification
REQ-039 Reset, then fetch_pc=0x100 -> pred_taken=0, pred_target=0x104.
REQ-040 beq at dec_pc=0x100 with imm=0x40, op1=op2=5, dp_taken=0 -> mispredict=1 and correct_pc=0x140; next lookup of 0x100 gives pred_taken=1 and target 0x140.
REQ-041 Branch taken twice then not-taken once -> counters 10, 11, 10, and it is still predicted taken.
REQ-042 blt with br_fwsel1=1, fw_data=0xFFFFFFFF, rs2_data=0 -> taken; bltu with the same operands -> not taken.
REQ-043 jalr with op1=0x2001, imm=0 -> correct_pc=0x2000.
REQ-044 Mispredict with stall=1 -> mispredict=0 and the BTB is unchanged after the edge.

Source files
------------

// File: rtl/branch_prediction_unit_pkg.sv
// branch_prediction_unit_pkg: shared opcode/funct3 constants and BTB counter type
`ifndef BPU_CONSTANTS
`define BPU_CONSTANTS
`define OPCODE_SIZE_C 7
`define BTYPE_OP_C 7'b1100011
`define JALR_OP_C 7'b1100111
`define F3_BEQ_C 3'b000
`define F3_BNE_C 3'b001
`define F3_BLT_C 3'b100
`define F3_BGE_C 3'b101
`define F3_BLTU_C 3'b110
`define F3_BGEU_C 3'b111
`endif
package branch_prediction_unit_pkg;
  localparam int OPCODE_SIZE = `OPCODE_SIZE_C;
  localparam logic [OPCODE_SIZE-1:0] BTYPE_OP = `BTYPE_OP_C;
  localparam logic [OPCODE_SIZE-1:0] JALR_OP = `JALR_OP_C;
  localparam logic [2:0] F3_BEQ = `F3_BEQ_C;
  localparam logic [2:0] F3_BNE = `F3_BNE_C;
  localparam logic [2:0] F3_BLT = `F3_BLT_C;
  localparam logic [2:0] F3_BGE = `F3_BGE_C;
  localparam logic [2:0] F3_BLTU = `F3_BLTU_C;
  localparam logic [2:0] F3_BGEU = `F3_BGEU_C;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;
  function automatic ctr_t next_ctr(input ctr_t c, input logic taken);
    return taken ? (c == ST ? ST : ctr_t'(c + 2'd1)) : (c == SNT ? SNT : ctr_t'(c - 2'd1));
  endfunction
endpackage

// File: rtl/branch_prediction_unit_cond.sv
// bpu_cond: combinational branch-condition evaluation for the six legal funct3 codes
module bpu_cond
  import branch_prediction_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic        taken,
  output logic        valid
);
  logic eq, lt, ltu;
  assign eq = op1 == op2;
  assign lt = $signed(op1) < $signed(op2);
  assign ltu = op1 < op2;
  assign valid = funct3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU};
  assign taken = funct3 == F3_BEQ ? eq :
                 funct3 == F3_BNE ? !eq :
                 funct3 == F3_BLT ? lt :
                 funct3 == F3_BGE ? !lt :
                 funct3 == F3_BLTU ? ltu :
                 funct3 == F3_BGEU ? !ltu : 1'b0;
endmodule

// File: rtl/branch_prediction_unit.sv
// branch_prediction_unit: BTB lookup in Fetch, branch/jalr resolution and BTB training in Decode
module branch_prediction_unit
  import branch_prediction_unit_pkg::*;
#(
  parameter int BTB_LOGSIZE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            fetch_pc,
  input  logic                   stall,
  input  logic [OPCODE_SIZE-1:0] opcode,
  input  logic [2:0]             funct3,
  input  logic [31:0]            dec_pc,
  input  logic [31:0]            dec_imm,
  input  logic [31:0]            rs1_data,
  input  logic [31:0]            rs2_data,
  input  logic [31:0]            fw_data,
  input  logic                   br_fwsel1,
  input  logic                   br_fwsel2,
  output logic                   pred_taken,
  output logic [31:0]            pred_target,
  output logic                   mispredict,
  output logic [31:0]            correct_pc
);
  localparam int N = 1 << BTB_LOGSIZE;
  localparam int TW = 30 - BTB_LOGSIZE;
  logic [N-1:0] btb_valid;
  logic [TW-1:0] btb_tag [N];
  logic [31:0] btb_target [N];
  ctr_t btb_ctr [N];
  logic dp_taken, dp_loaded;
  logic [31:0] dp_target;
  logic [BTB_LOGSIZE-1:0] f_idx, d_idx;
  logic [31:0] op1, op2, res_target;
  logic is_b, is_j, cond_taken, cond_valid, res_valid, res_taken, d_hit;
  assign f_idx = fetch_pc[BTB_LOGSIZE+1:2];
  assign d_idx = dec_pc[BTB_LOGSIZE+1:2];
  assign pred_taken = !rst && btb_valid[f_idx] && btb_tag[f_idx] == fetch_pc[31:BTB_LOGSIZE+2] && btb_ctr[f_idx][1];
  assign pred_target = pred_taken ? btb_target[f_idx] : fetch_pc + 32'd4;
  assign op1 = br_fwsel1 ? fw_data : rs1_data;
  assign op2 = br_fwsel2 ? fw_data : rs2_data;
  bpu_cond u_cond (
    .funct3 (funct3),
    .op1    (op1),
    .op2    (op2),
    .taken  (cond_taken),
    .valid  (cond_valid)
  );
  assign is_b = opcode == BTYPE_OP;
  assign is_j = opcode == JALR_OP;
  assign res_valid = is_j || (is_b && cond_valid);
  assign res_taken = is_j || (is_b && cond_valid && cond_taken);
  assign res_target = is_j ? ((op1 + dec_imm) & ~32'd1) : dec_pc + dec_imm;
  assign correct_pc = res_taken ? res_target : dec_pc + 32'd4;
  // Decode holds no real prediction until the first non-stalled edge after reset
  assign mispredict = !rst && !stall && dp_loaded && res_valid &&
                      (res_taken != dp_taken || (res_taken && res_target != dp_target));
  assign d_hit = btb_valid[d_idx] && btb_tag[d_idx] == dec_pc[31:BTB_LOGSIZE+2];
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid <= '0;
      for (int i = 0; i < N; i++) begin
        btb_tag[i] <= '0;
        btb_target[i] <= '0;
        btb_ctr[i] <= WNT;
      end
      dp_taken <= 1'b0;
      dp_target <= '0;
      dp_loaded <= 1'b0;
    end else if (!stall) begin
      dp_taken <= pred_taken;
      dp_target <= pred_target;
      dp_loaded <= 1'b1;
      if (res_valid && d_hit) begin
        btb_ctr[d_idx] <= next_ctr(btb_ctr[d_idx], res_taken);
        if (res_taken) btb_target[d_idx] <= res_target;
      end else if (res_taken) begin
        btb_valid[d_idx] <= 1'b1;
        btb_tag[d_idx] <= dec_pc[31:BTB_LOGSIZE+2];
        btb_target[d_idx] <= res_target;
        btb_ctr[d_idx] <= WT;
      end
    end
  end
endmodule
